truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Sequencer that exhaustively exercises one combinational N-input, 1-output circuit under test (CUT) and checks it against an expected truth table.
- Drives every input vector 0 … 2^N_IN-1 in ascending order and waits a programmable settle time per vector.
- Samples the CUT output into a truth-table register and flags mismatches against the expected mask.
- Sits between a bench or top-level control and the combinational lab circuits: 3-input functions, comparators, decoder output bits.

Parameters:
N_IN, 3, number of CUT inputs; TT_W = 2^N_IN truth-table width (8 by default)
SETTLE_CYCLES, 2, idle cycles per vector before sampling; legal range 0..15

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  cancel sweep; synchronous, any state
exp_tt  in  TT_W  expected output; bit i = CUT output for input vector i (MSB of vector = first CUT input)
cut_in  out  N_IN  vector driven to CUT, registered
cut_out  in  1  CUT output
busy  out  1  high in SETTLE/SAMPLE
done  out  1  one-cycle pulse at end of a completed sweep
pass  out  1  valid when not busy; 1 = all TT_W vectors matched
tt  out  TT_W  captured truth table
fail_count  out  N_IN+1  number of mismatching vectors (0..TT_W)
first_fail  out  N_IN  lowest mismatching vector index; 0 if none

Behaviour:
- Reset (rst_n=0, async): state IDLE, cut_in=0, busy=0, done=0, pass=0, tt=0, fail_count=0, first_fail=0, settle counter=0, latched expected=0.
- States:
  - IDLE: start=1 -> latch exp_tt, idx=0, cut_in=0, clear tt/fail_count/first_fail, pass=0, load counter=SETTLE_CYCLES, go to SETTLE.
  - SETTLE: counter==0 -> SAMPLE; otherwise decrement.
  - SAMPLE: tt[idx]<=cut_out. If cut_out != exp[idx]: fail_count++; first_fail<=idx if this is the first mismatch. If idx==TT_W-1 -> DONE; else idx++, cut_in<=idx+1, reload counter, go to SETTLE.
  - DONE: done=1 for this cycle only; pass<=(final fail_count==0, including the last sample); go to IDLE.
- Timing:
  - cut_in is stable for SETTLE_CYCLES+1 cycles per vector, and cut_in changes only on SAMPLE->SETTLE.
  - done rises exactly TT_W*(SETTLE_CYCLES+1) edges after the start-accepting edge: 24 at defaults.
  - SETTLE_CYCLES=0: each vector takes 1 SETTLE + 1 SAMPLE cycle.
- Signal rules:
  - exp_tt changes during a sweep are ignored; the copy latched at start is used.
  - start while busy or in DONE is ignored; no queueing.
  - abort has priority over start and over all state transitions: next state IDLE, cut_in=0, no done pulse, pass=0, tt and counts keep their partial values.
  - start and abort high in the same IDLE cycle: abort wins, no sweep.
  - pass, tt, fail_count and first_fail hold after DONE until the next accepted start or reset.
- Reset mid-sweep: immediate return to reset values; no done pulse.
- Widths: fail_count never wraps (max TT_W fits in N_IN+1 bits). idx stops at TT_W-1 and is not incremented past it.

Decomposition:
- Package tt_sweep_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}
  - function tt_width(n)=2^n
  - localparam SETTLE_W=4
- One natural sub-module, tt_settle_timer: loadable down-counter with zero flag, parameterised by SETTLE_W.
- FSM, index register and capture/compare logic stay in the top module.

Test Plan:
1. Bench CUT model implements minterms {2,3,4,6,7}; exp_tt=8'hDC; pulse start -> cut_in steps 0..7, each held 3 cycles; done exactly 24 edges after the start edge; tt=8'hDC, pass=1, fail_count=0, first_fail=0.
2. Same CUT, exp_tt=8'hDE (bit 1 wrong) -> tt=8'hDC, pass=0, fail_count=1, first_fail=1; toggle exp_tt mid-sweep to 8'h00 -> results unchanged.
3. CUT stuck at 1, exp_tt=8'h00 -> fail_count=8 (4'b1000, no wrap), first_fail=0, tt=8'hFF, pass=0.
4. Abort asserted at vector 4 during SETTLE -> IDLE next cycle, cut_in=0, no done pulse, pass=0, tt bits 0..3 hold captured values; start re-pulsed while busy in a new sweep -> ignored, no restart.
5. rst_n dropped asynchronously mid-SAMPLE -> all outputs at reset values before the next edge; a fresh start after release gives a full 24-cycle sweep.
6. SETTLE_CYCLES=0 build, exp_tt=8'hDC, correct CUT -> cut_in changes every 2 cycles; done 16 edges after start; pass=1.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// -----------------------------------------------------------------------------
// tt_sweep_pkg
// Shared types and helpers for the truth-table sweeper.
//   state_t   : sweeper FSM states
//   SETTLE_W  : width of the per-vector settle counter (settle range 0..15)
//   tt_width  : truth-table width for an n-input circuit (2^n)
// -----------------------------------------------------------------------------
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int SETTLE_W = 4;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
// Bundles the control, CUT and result signals of the truth-table sweeper.
//   master : control side plus the CUT output (drives start/abort/exp_tt/cut_out)
//   slave  : the sweeper (drives cut_in, status and results)
//
// Handshake: start is a level sampled only while the sweeper is idle; there is
// no ready signal -- acceptance is visible as busy rising on the next cycle.
// A start seen while busy or in the done cycle is dropped, never queued.
// abort is synchronous and wins over start and over every state transition.
// done is a one-cycle pulse; pass/tt/fail_count/first_fail are valid whenever
// busy is low and hold until the next accepted start.
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  localparam int TT_W = tt_sweep_pkg::tt_width(N_IN);

  logic                  start;
  logic                  abort;
  logic [TT_W-1:0]       exp_tt;
  logic [N_IN-1:0]       cut_in;
  logic                  cut_out;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [TT_W-1:0]       tt;
  logic [N_IN:0]         fail_count;
  logic [N_IN-1:0]       first_fail;
  tt_sweep_pkg::state_t  dbg_state;

  modport master (
    output start, abort, exp_tt, cut_out,
    input  cut_in, busy, done, pass, tt, fail_count, first_fail, dbg_state
  );

  modport slave (
    input  start, abort, exp_tt, cut_out,
    output cut_in, busy, done, pass, tt, fail_count, first_fail, dbg_state
  );

endinterface

// File: rtl/tt_settle_timer.sv
// -----------------------------------------------------------------------------
// tt_settle_timer
// Loadable down-counter with a zero flag; counts settle cycles per vector.
//   clk, rst_n  : clock, asynchronous active-low reset (count -> 0)
//   i_load      : load i_load_val (has priority over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement by one, saturating at zero
//   o_zero      : count is zero
// -----------------------------------------------------------------------------
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Exhaustively drives an N_IN-input combinational circuit with vectors
// 0..2^N_IN-1, waits a settle time per vector, captures the circuit output
// into a truth table and compares it against an expected table latched at
// start.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : truth_table_sweeper_if.slave
//                in : start, abort, exp_tt, cut_out
//                out: cut_in (registered), busy, done, pass, tt, fail_count,
//                     first_fail, dbg_state (current FSM state)
// Parameters:
//   N_IN          : number of CUT inputs
//   SETTLE_CYCLES : settle cycles per vector, 0..15
// -----------------------------------------------------------------------------
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  bus
);

  localparam int TT_W = tt_width(N_IN);

  // A vector occupies SETTLE_CYCLES+1 cycles including its SAMPLE cycle, with
  // a floor of one SETTLE + one SAMPLE. The SETTLE state spends load+1 cycles,
  // so the timer is loaded with SETTLE_CYCLES-1 (clamped at zero).
  localparam logic [SETTLE_W-1:0] LOAD_VAL =
    (SETTLE_CYCLES == 0) ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);

  state_t          r_state;
  logic [N_IN-1:0] r_idx;
  logic [TT_W-1:0] r_exp;
  logic [N_IN-1:0] r_cut_in;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [TT_W-1:0] r_tt;
  logic [N_IN:0]   r_fail_count;
  logic [N_IN-1:0] r_first_fail;

  logic            w_accept;
  logic            w_last;
  logic            w_mismatch;
  logic [N_IN:0]   w_fail_next;
  logic            w_timer_load;
  logic            w_timer_dec;
  logic            w_timer_zero;

  assign w_accept     = (r_state == IDLE) && bus.start && !bus.abort;
  assign w_last       = &r_idx;
  assign w_mismatch   = (bus.cut_out != r_exp[r_idx]);
  // Fail count including the current sample, so the pass verdict on the last
  // vector sees its own mismatch.
  assign w_fail_next  = r_fail_count + {{N_IN{1'b0}}, w_mismatch};
  assign w_timer_load = !bus.abort &&
                        (w_accept || ((r_state == SAMPLE) && !w_last));
  assign w_timer_dec  = (r_state == SETTLE);

  tt_settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_timer_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_timer_dec),
    .o_zero     (w_timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_exp        <= '0;
      r_cut_in     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_tt         <= '0;
      r_fail_count <= '0;
      r_first_fail <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        // Partial tt and counts are kept for inspection.
        r_state  <= IDLE;
        r_cut_in <= '0;
        r_busy   <= 1'b0;
        r_pass   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_exp        <= bus.exp_tt;
              r_idx        <= '0;
              r_cut_in     <= '0;
              r_tt         <= '0;
              r_fail_count <= '0;
              r_first_fail <= '0;
              r_pass       <= 1'b0;
              r_busy       <= 1'b1;
              r_state      <= SETTLE;
            end
          end
          SETTLE: begin
            if (w_timer_zero) begin
              r_state <= SAMPLE;
            end
          end
          SAMPLE: begin
            r_tt[r_idx] <= bus.cut_out;
            if (w_mismatch) begin
              r_fail_count <= w_fail_next;
              if (r_fail_count == '0) begin
                r_first_fail <= r_idx;
              end
            end
            if (w_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_pass  <= (w_fail_next == '0);
            end else begin
              r_idx    <= r_idx + 1'b1;
              r_cut_in <= r_idx + 1'b1;
              r_state  <= SETTLE;
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.cut_in     = r_cut_in;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.tt         = r_tt;
  assign bus.fail_count = r_fail_count;
  assign bus.first_fail = r_first_fail;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Two sweepers share clock/reset: dut2 (SETTLE_CYCLES=2) and dut0
// (SETTLE_CYCLES=0). Each drives its own copy of a behavioural CUT defined by
// cut_fn (bit i = CUT output for vector i).
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;
  import tt_sweep_pkg::*;

  localparam int N_IN = 3;
  localparam int TT_W = 8;
  localparam int RW   = TT_W + 1 + (N_IN + 1) + N_IN;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs and CUT models ----------------
  truth_table_sweeper_if #(.N_IN(N_IN)) b2 ();
  truth_table_sweeper_if #(.N_IN(N_IN)) b0 ();

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYCLES(2)) dut2 (
    .clk (clk), .rst_n (rst_n), .bus (b2)
  );
  truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYCLES(0)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (b0)
  );

  logic            sel;     // 1 = dut0 is the device under test
  logic            start;
  logic            abort;
  logic [TT_W-1:0] exp_tt;
  logic [TT_W-1:0] cut_fn;

  assign b2.start   = start & ~sel;
  assign b0.start   = start &  sel;
  assign b2.abort   = abort;
  assign b0.abort   = abort;
  assign b2.exp_tt  = exp_tt;
  assign b0.exp_tt  = exp_tt;
  assign b2.cut_out = cut_fn[b2.cut_in];
  assign b0.cut_out = cut_fn[b0.cut_in];

  logic [N_IN-1:0] m_cut_in;
  logic            m_busy, m_done, m_pass;
  logic [TT_W-1:0] m_tt;
  logic [N_IN:0]   m_fc;
  logic [N_IN-1:0] m_ff;
  state_t          m_state;

  assign m_cut_in = sel ? b0.cut_in     : b2.cut_in;
  assign m_busy   = sel ? b0.busy       : b2.busy;
  assign m_done   = sel ? b0.done       : b2.done;
  assign m_pass   = sel ? b0.pass       : b2.pass;
  assign m_tt     = sel ? b0.tt         : b2.tt;
  assign m_fc     = sel ? b0.fail_count : b2.fail_count;
  assign m_ff     = sel ? b0.first_fail : b2.first_fail;
  assign m_state  = sel ? b0.dbg_state  : b2.dbg_state;

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [RW-1:0] pack(input logic [TT_W-1:0] t, input logic p,
                                         input logic [N_IN:0] fc, input logic [N_IN-1:0] ff);
    return {t, p, fc, ff};
  endfunction

  // ---------------- driver: one full sweep ----------------
  task automatic sweep(input string name, input bit s0, input logic [TT_W-1:0] fn,
                       input logic [TT_W-1:0] exp, input logic [TT_W-1:0] mid,
                       input logic [RW-1:0] want, input int repulse_k);
    int per_vec, total, done_at, cut_err, busy_err;
    logic [RW-1:0] req;
    per_vec = s0 ? 2 : 3;
    total   = TT_W * per_vec;
    sel     = s0;
    cut_fn  = fn;
    exp_tt  = exp;
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(want);
    @(negedge clk);
    start    = 1'b0;
    done_at  = -1;
    cut_err  = 0;
    busy_err = 0;
    // k counts rising edges since the start-accepting edge.
    for (int k = 0; k < total + 20; k++) begin
      if (m_done) begin
        done_at = k;
        break;
      end
      if (m_cut_in !== 3'(k / per_vec)) cut_err++;
      if (m_busy !== 1'b1) busy_err++;
      if (k == 4 * per_vec) exp_tt = mid;
      start = (k == repulse_k);
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_done_edge"}, done_at, total);
    check({name, "_cut_in_seq_errs"}, cut_err, 0);
    check({name, "_busy_errs"}, busy_err, 0);
    check({name, "_busy_at_done"}, m_busy, 1'b0);
    req = exp_q.pop_front();
    check({name, "_result"}, pack(m_tt, m_pass, m_fc, m_ff), req);
    // start during the done cycle must be dropped
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_start_in_done_state"}, {m_state, m_done}, {IDLE, 1'b0});
    repeat (3) @(negedge clk);
    check({name, "_hold"}, pack(m_tt, m_pass, m_fc, m_ff), req);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string           name;
    bit              s0;
    logic [TT_W-1:0] fn;
    logic [TT_W-1:0] exp;
    logic [TT_W-1:0] mid;
    logic [TT_W-1:0] tt_e;
    logic            pass_e;
    logic [N_IN:0]   fc_e;
    logic [N_IN-1:0] ff_e;
    int              repulse_k;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int dcnt;
    // Minterms {2,3,4,6,7} -> 8'hDC.
    vecs[0] = '{"match",    1'b0, 8'hDC, 8'hDC, 8'hDC, 8'hDC, 1'b1, 4'd0, 3'd0, -1};
    vecs[1] = '{"bit1",     1'b0, 8'hDC, 8'hDE, 8'h00, 8'hDC, 1'b0, 4'd1, 3'd1,  5};
    vecs[2] = '{"stuck1",   1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, 4'd8, 3'd0, -1};
    vecs[3] = '{"last_vec", 1'b0, 8'h80, 8'h00, 8'h00, 8'h80, 1'b0, 4'd1, 3'd7, -1};
    vecs[4] = '{"two_miss", 1'b0, 8'h00, 8'h28, 8'h28, 8'h00, 1'b0, 4'd2, 3'd3, -1};
    vecs[5] = '{"settle0",  1'b1, 8'hDC, 8'hDC, 8'hDC, 8'hDC, 1'b1, 4'd0, 3'd0, -1};

    sel    = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    exp_tt = '0;
    cut_fn = 8'hDC;

    // reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", pack(m_tt, m_pass, m_fc, m_ff), '0);
    check("reset_status", {m_cut_in, m_busy, m_done, m_state}, {3'd0, 1'b0, 1'b0, IDLE});
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      sweep(vecs[i].name, vecs[i].s0, vecs[i].fn, vecs[i].exp, vecs[i].mid,
            pack(vecs[i].tt_e, vecs[i].pass_e, vecs[i].fc_e, vecs[i].ff_e),
            vecs[i].repulse_k);
    end

    // abort during SETTLE of vector 4
    sel    = 1'b0;
    cut_fn = 8'hDC;
    exp_tt = 8'hDC;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_pre", {m_state, m_cut_in}, {SETTLE, 3'd4});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_status", {m_state, m_cut_in, m_busy, m_pass}, {IDLE, 3'd0, 1'b0, 1'b0});
    check("abort_partial_tt", m_tt, 8'h0C);
    check("abort_fail_count", m_fc, 4'd0);
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (m_done || m_busy) dcnt++;
      @(negedge clk);
    end
    check("abort_no_done", dcnt, 0);

    // start and abort in the same idle cycle
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_same", {m_state, m_busy}, {IDLE, 1'b0});

    // asynchronous reset mid-SAMPLE
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    while (!(m_state == SAMPLE && m_cut_in == 3'd5) && dcnt < 100) begin
      dcnt++;
      @(negedge clk);
    end
    check("rst_reach_sample5", dcnt < 100, 1'b1);
    check("rst_pre_tt", m_tt, 8'h1C);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", pack(m_tt, m_pass, m_fc, m_ff), '0);
    check("rst_async_status", {m_cut_in, m_busy, m_done, m_state}, {3'd0, 1'b0, 1'b0, IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    sweep("after_reset", 1'b0, 8'hDC, 8'hDC, 8'hDC, pack(8'hDC, 1'b1, 4'd0, 3'd0), -1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
